// File: rtl/tube_scan_ctrl.sv
// Dual 4-digit multiplexed tube scanner with a small register bank.
// Steps one digit at a time, with an optional blanking gap between digits.
module tube_scan_ctrl #(
  parameter int unsigned DEFAULT_DIV = 500000,
  parameter int unsigned BLANK_CYC   = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [1:0]  addr,
  input  logic [3:0]  byteen,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic [31:0] disp_val,
  output logic [3:0]  sel0,
  output logic [3:0]  sel1,
  output logic [3:0]  nib0,
  output logic [3:0]  nib1,
  output logic        frame_done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHOW  = 2'd1,
    BLANK = 2'd2
  } state_t;

  localparam bit HAS_BLANK = (BLANK_CYC != 0);
  localparam logic [31:0] BLANK_LAST =
    HAS_BLANK ? 32'(BLANK_CYC - 1) : 32'd0;

  state_t      state, state_nx;
  logic        en, blank_en, en_nx, ctrl_wr;
  logic [31:0] div, div_min;
  logic [31:0] eff_div, eff_div_nx;
  logic [31:0] cnt, cnt_nx;
  logic [1:0]  digit, digit_nx, enter_digit;
  logic [3:0]  sel, sel_nx, nib0_nx, nib1_nx;
  logic        frame_nx, enter;

  // A write clearing en takes effect on the same edge it is written.
  assign ctrl_wr = we && (addr == 2'd0) && byteen[0];
  assign en_nx   = ctrl_wr ? wdata[0] : en;
  assign div_min = (div < 32'd2) ? 32'd2 : div;
  assign sel0    = sel;
  assign sel1    = sel;

  // Bus register writes, byte-masked; reset wins over a write.
  always_ff @(posedge clk) begin
    if (reset) begin
      en       <= 1'b0;
      blank_en <= 1'b0;
      div      <= 32'(DEFAULT_DIV);
    end else if (we) begin
      if (addr == 2'd0 && byteen[0]) begin
        en       <= wdata[0];
        blank_en <= wdata[1];
      end
      if (addr == 2'd1) begin
        for (int i = 0; i < 4; i++) begin
          if (byteen[i]) div[8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

  // Combinational register readback.
  always_comb begin
    rdata = 32'd0;
    case (addr)
      2'd0: rdata = {30'd0, blank_en, en};
      2'd1: rdata = div;
      2'd2: rdata = {22'd0, state, 6'd0, digit};
      default: rdata = 32'd0;
    endcase
  end

  // Scan sequencing: next state, counter and display latches.
  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt;
    eff_div_nx  = eff_div;
    digit_nx    = digit;
    sel_nx      = sel;
    nib0_nx     = nib0;
    nib1_nx     = nib1;
    frame_nx    = 1'b0;
    enter       = 1'b0;
    enter_digit = digit + 2'd1;
    case (state)
      IDLE: begin
        if (en_nx) begin
          enter       = 1'b1;
          enter_digit = 2'd0;
        end
      end
      SHOW: begin
        if (!en_nx) begin
          state_nx = IDLE;
        end else if (cnt == eff_div - 32'd1) begin
          frame_nx = (digit == 2'd3);
          if (blank_en && HAS_BLANK) begin
            state_nx = BLANK;
            cnt_nx   = 32'd0;
            sel_nx   = 4'd0;
          end else begin
            enter = 1'b1;
          end
        end else begin
          cnt_nx = cnt + 32'd1;
        end
      end
      BLANK: begin
        if (!en_nx) begin
          state_nx = IDLE;
        end else if (cnt == BLANK_LAST) begin
          enter = 1'b1;
        end else begin
          cnt_nx = cnt + 32'd1;
        end
      end
      default: state_nx = IDLE;
    endcase
    if (state_nx == IDLE) begin
      cnt_nx   = 32'd0;
      digit_nx = 2'd0;
      sel_nx   = 4'd0;
    end
    if (enter) begin
      state_nx   = SHOW;
      cnt_nx     = 32'd0;
      digit_nx   = enter_digit;
      eff_div_nx = div_min;
      sel_nx     = 4'b0001 << enter_digit;
      nib0_nx    = disp_val[{enter_digit, 2'b00} +: 4];
      nib1_nx    = disp_val[{1'b1, enter_digit, 2'b00} +: 4];
    end
  end

  // Scan state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= 32'd0;
      eff_div    <= 32'd2;
      digit      <= 2'd0;
      sel        <= 4'd0;
      nib0       <= 4'd0;
      nib1       <= 4'd0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      eff_div    <= eff_div_nx;
      digit      <= digit_nx;
      sel        <= sel_nx;
      nib0       <= nib0_nx;
      nib1       <= nib1_nx;
      frame_done <= frame_nx;
    end
  end

endmodule

// File: tb/tb_tube_scan_ctrl.sv
// Bench for tube_scan_ctrl: countdown-based reference model,
// directed literal checks, then randomized bus/display traffic.
module tb_tube_scan_ctrl;

  localparam int DDIV = 4;
  localparam int BC   = 2;

  logic        clk = 0;
  logic        reset, we;
  logic [1:0]  addr;
  logic [3:0]  byteen;
  logic [31:0] wdata, rdata, disp_val;
  logic [3:0]  sel0, sel1, nib0, nib1;
  logic        frame_done;

  int errors = 0;
  int checks = 0;

  tube_scan_ctrl #(.DEFAULT_DIV(DDIV), .BLANK_CYC(BC)) dut (
    .clk(clk), .reset(reset), .we(we), .addr(addr),
    .byteen(byteen), .wdata(wdata), .rdata(rdata),
    .disp_val(disp_val), .sel0(sel0), .sel1(sel1),
    .nib0(nib0), .nib1(nib1), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // Reference model: mode 0 idle, 1 showing, 2 blanking;
  // m_left counts down the cycles left in the current phase.
  bit          m_valid = 0;
  int          m_mode, m_digit, m_left;
  bit          m_en, m_blank_en, m_frame;
  logic [31:0] m_div;
  logic [3:0]  m_sel, m_nib0, m_nib1;

  task automatic enter(input int d, input logic [31:0] dv);
    m_mode  = 1;
    m_digit = d;
    m_left  = (dv < 2) ? 2 : int'(dv);
    m_sel   = 4'(1 << d);
    m_nib0  = 4'((disp_val >> (4 * d)) & 32'hF);
    m_nib1  = 4'((disp_val >> (16 + 4 * d)) & 32'hF);
  endtask

  always @(posedge clk) begin
    bit o_blank, en_nx, cw;
    logic [31:0] o_div;
    o_blank = m_blank_en;
    o_div   = m_div;
    cw      = we && addr == 2'd0 && byteen[0];
    en_nx   = cw ? wdata[0] : m_en;
    m_frame = 0;
    if (reset) begin
      m_valid = 1;
      m_mode = 0; m_digit = 0; m_left = 0;
      m_en = 0; m_blank_en = 0; m_div = DDIV;
      m_sel = 0; m_nib0 = 0; m_nib1 = 0;
    end else begin
      if (cw) begin
        m_en       = wdata[0];
        m_blank_en = wdata[1];
      end
      if (we && addr == 2'd1)
        for (int i = 0; i < 4; i++)
          if (byteen[i]) m_div[8*i +: 8] = wdata[8*i +: 8];
      if (m_mode == 0) begin
        if (en_nx) enter(0, o_div);
      end else if (!en_nx) begin
        m_mode = 0; m_digit = 0; m_sel = 0;
      end else begin
        m_left--;
        if (m_left == 0) begin
          if (m_mode == 1) begin
            if (m_digit == 3) m_frame = 1;
            if (o_blank && BC > 0) begin
              m_mode = 2; m_left = BC; m_sel = 0;
            end else enter((m_digit + 1) % 4, o_div);
          end else enter((m_digit + 1) % 4, o_div);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t",
               name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_rdata(input logic [1:0] a);
    case (a)
      2'd0: return {30'd0, m_blank_en, m_en};
      2'd1: return m_div;
      2'd2: return {22'd0, 2'(m_mode), 6'd0, 2'(m_digit)};
      default: return 32'd0;
    endcase
  endfunction

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (m_valid) begin
      chk("sel0", {28'd0, sel0}, {28'd0, m_sel});
      chk("sel1", {28'd0, sel1}, {28'd0, m_sel});
      chk("nib0", {28'd0, nib0}, {28'd0, m_nib0});
      chk("nib1", {28'd0, nib1}, {28'd0, m_nib1});
      chk("frame_done", {31'd0, frame_done}, {31'd0, m_frame});
      chk("rdata", rdata, m_rdata(addr));
    end
  end

  task automatic wr(input logic [1:0] a, input logic [3:0] be,
                    input logic [31:0] d);
    addr = a; byteen = be; wdata = d; we = 1;
    @(posedge clk); #2;
    we = 0; byteen = 0;
  endtask

  task automatic wait_pulse(output int k);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!frame_done && k < 200);
  endtask

  initial begin
    int k;
    reset = 1; we = 0; addr = 2'd1; byteen = 0;
    wdata = 0; disp_val = 32'h87654321;
    repeat (3) @(posedge clk);
    #2 reset = 0;
    @(negedge clk);
    chk("reset_sel0", {28'd0, sel0}, 32'd0);
    chk("reset_div", rdata, 32'd4);

    wr(2'd1, 4'b0001, 32'hFFFFFF08);
    @(negedge clk);
    chk("div_byteen", rdata, 32'h8);
    wr(2'd1, 4'hF, 32'd4);

    wr(2'd0, 4'h1, 32'd1);
    for (int n = 0; n < 32; n++) begin
      @(negedge clk);
      if (n < 16) begin
        chk("lit_sel0", {28'd0, sel0}, 32'(1 << (n / 4)));
        chk("lit_nib0", {28'd0, nib0}, 32'(n / 4 + 1));
        chk("lit_nib1", {28'd0, nib1}, 32'(n / 4 + 5));
      end
      chk("lit_frame", {31'd0, frame_done}, (n == 16) ? 32'd1 : 32'd0);
    end

    wr(2'd0, 4'h1, 32'd3);
    wait_pulse(k);
    wait_pulse(k);
    wait_pulse(k);
    chk("blank_period", k, 24);

    addr = 2'd2;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (rdata[9:0] != 10'h102 && k < 200);
    chk("wait_digit2", {31'd0, k >= 200}, 32'd0);
    wr(2'd0, 4'h1, 32'd0);
    addr = 2'd2;
    @(negedge clk);
    chk("dis_sel0", {28'd0, sel0}, 32'd0);
    chk("dis_frame", {31'd0, frame_done}, 32'd0);
    chk("dis_status", rdata, 32'd0);
    wr(2'd0, 4'h1, 32'd1);
    @(negedge clk);
    chk("reen_sel0", {28'd0, sel0}, 32'd1);
    chk("reen_nib0", {28'd0, nib0}, 32'd1);

    wr(2'd1, 4'hF, 32'd0);
    wait_pulse(k);
    wait_pulse(k);
    wait_pulse(k);
    chk("div0_period", k, 8);

    for (int c = 0; c < 4000; c++) begin
      @(posedge clk); #2;
      reset  = ($urandom % 600) == 0;
      we     = ($urandom % 4) == 0;
      addr   = 2'($urandom);
      byteen = 4'($urandom);
      if (addr == 2'd1) wdata = $urandom_range(0, 7);
      else wdata = {$urandom, 1'b0} |
                   32'(($urandom % 5) != 0);
      if (($urandom % 8) == 0) disp_val = $urandom;
    end
    @(posedge clk); #2;
    reset = 0; we = 0;
    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
